// File: rtl/pong_match_if.sv
// Signal bundle between the match controller and the game/display side.
// The slave modport is the controller; the master modport is the game/display side.
interface pong_match_if #(
    parameter int X_POS_W = 10,
    parameter int SCORE_W = 4
);
    logic               new_frame_i;
    logic               start_i;
    logic               pause_i;
    logic [X_POS_W-1:0] ball_x_i;
    logic               play_en_o;
    logic               ball_serve_o;
    logic               serve_dir_o;
    logic [SCORE_W-1:0] score_l_o;
    logic [SCORE_W-1:0] score_r_o;
    logic               game_over_o;
    logic               winner_o;

    modport master (
        output new_frame_i, start_i, pause_i, ball_x_i,
        input  play_en_o, ball_serve_o, serve_dir_o, score_l_o, score_r_o,
               game_over_o, winner_o
    );

    modport slave (
        input  new_frame_i, start_i, pause_i, ball_x_i,
        output play_en_o, ball_serve_o, serve_dir_o, score_l_o, score_r_o,
               game_over_o, winner_o
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match flow: attract, serve countdown, play, pause and game over,
// with score keeping and gating of ball motion.
module pong_match_ctrl #(
    parameter int X_POS_W      = 10,
    parameter int GOAL_L       = 0,
    parameter int GOAL_R       = 632,
    parameter int WIN_SCORE    = 7,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pong_match_if.slave  m_if
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [X_POS_W-1:0] GOAL_L_C = X_POS_W'(GOAL_L);
    localparam logic [X_POS_W-1:0] GOAL_R_C = X_POS_W'(GOAL_R);
    localparam logic [SCORE_W-1:0] WIN_C    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   LOAD_C   = CNT_W'(SERVE_FRAMES);

    typedef enum logic [2:0] {ST_IDLE, ST_SERVE, ST_PLAY, ST_PAUSE, ST_OVER} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               play_en_q, play_en_d;
    logic               ball_serve_q, ball_serve_d;
    logic               game_over_q, game_over_d;
    logic               start_prev_q, pause_prev_q;

    logic               start_press, pause_press, goal_l, goal_r;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;

    // Previous-value registers reset to 1 so a key held through reset is not a press.
    assign start_press = m_if.start_i & ~start_prev_q;
    assign pause_press = m_if.pause_i & ~pause_prev_q;
    assign goal_l      = m_if.new_frame_i && (m_if.ball_x_i <= GOAL_L_C);
    assign goal_r      = m_if.new_frame_i && (m_if.ball_x_i >= GOAL_R_C);
    assign score_l_inc = score_l_q + SCORE_W'(1);
    assign score_r_inc = score_r_q + SCORE_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_press) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = 1'b1;
                    cnt_d       = LOAD_C;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (m_if.new_frame_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A goal takes precedence over a pause press in the same cycle.
                if (goal_l) begin
                    score_r_d   = score_r_inc;
                    serve_dir_d = 1'b0;
                    if (score_r_inc == WIN_C) begin
                        winner_d = 1'b1;
                        state_d  = ST_OVER;
                    end else begin
                        cnt_d   = LOAD_C;
                        state_d = ST_SERVE;
                    end
                end else if (goal_r) begin
                    score_l_d   = score_l_inc;
                    serve_dir_d = 1'b1;
                    if (score_l_inc == WIN_C) begin
                        winner_d = 1'b0;
                        state_d  = ST_OVER;
                    end else begin
                        cnt_d   = LOAD_C;
                        state_d = ST_SERVE;
                    end
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_press) state_d = ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
        play_en_d    = (state_d == ST_PLAY);
        ball_serve_d = (state_q == ST_SERVE) && (state_d == ST_PLAY);
        game_over_d  = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_dir_q  <= 1'b1;
            winner_q     <= 1'b0;
            play_en_q    <= 1'b0;
            ball_serve_q <= 1'b0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            play_en_q    <= play_en_d;
            ball_serve_q <= ball_serve_d;
            game_over_q  <= game_over_d;
            start_prev_q <= m_if.start_i;
            pause_prev_q <= m_if.pause_i;
        end
    end

    assign m_if.play_en_o    = play_en_q;
    assign m_if.ball_serve_o = ball_serve_q;
    assign m_if.serve_dir_o  = serve_dir_q;
    assign m_if.score_l_o    = score_l_q;
    assign m_if.score_r_o    = score_r_q;
    assign m_if.game_over_o  = game_over_q;
    assign m_if.winner_o     = winner_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl with SERVE_FRAMES=3 and WIN_SCORE=2.
module tb_pong_match_ctrl;
    localparam int X_POS_W = 10;
    localparam int SCORE_W = 4;

    localparam int S_PLAY_EN = 0, S_SERVE = 1, S_DIR = 2, S_SCORE_L = 3,
                   S_SCORE_R = 4, S_OVER = 5, S_WINNER = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    pong_match_if #(.X_POS_W(X_POS_W), .SCORE_W(SCORE_W)) m_if ();

    pong_match_ctrl #(
        .X_POS_W(X_POS_W), .GOAL_L(0), .GOAL_R(632), .WIN_SCORE(2),
        .SCORE_W(SCORE_W), .SERVE_FRAMES(3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .m_if (m_if)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_PLAY_EN: return 16'(m_if.play_en_o);
            S_SERVE:   return 16'(m_if.ball_serve_o);
            S_DIR:     return 16'(m_if.serve_dir_o);
            S_SCORE_L: return 16'(m_if.score_l_o);
            S_SCORE_R: return 16'(m_if.score_r_o);
            S_OVER:    return 16'(m_if.game_over_o);
            default:   return 16'(m_if.winner_o);
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = 16'(val);
        sb.push_back(e);
    endtask

    // wn < 0: winner is not meaningful for this cycle
    task automatic exp_out(input string tag, input int pe, input int bs, input int dir,
                           input int sl, input int sr, input int go, input int wn);
        push({tag, ".play_en"}, S_PLAY_EN, pe);
        push({tag, ".serve"},   S_SERVE,   bs);
        push({tag, ".dir"},     S_DIR,     dir);
        push({tag, ".score_l"}, S_SCORE_L, sl);
        push({tag, ".score_r"}, S_SCORE_R, sr);
        push({tag, ".over"},    S_OVER,    go);
        if (wn >= 0) push({tag, ".winner"}, S_WINNER, wn);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    // Drive one cycle of stimulus, record expected post-edge outputs, then compare.
    task automatic cyc(input string tag, input logic nf, input logic [X_POS_W-1:0] x,
                       input logic st, input logic ps,
                       input int pe, input int bs, input int dir, input int sl,
                       input int sr, input int go, input int wn);
        m_if.new_frame_i = nf;
        m_if.ball_x_i    = x;
        m_if.start_i     = st;
        m_if.pause_i     = ps;
        exp_out(tag, pe, bs, dir, sl, sr, go, wn);
        @(posedge clk);
        #1;
        m_if.new_frame_i = 1'b0;
        drain();
    endtask

    // Three frame strobes, with gaps, release the ball after the third.
    task automatic serve_seq(input string tag, input int dir, input int sl, input int sr);
        cyc({tag, ".f1"},  1'b1, 10'd300, 1'b0, 1'b0, 0, 0, dir, sl, sr, 0, -1);
        cyc({tag, ".g1"},  1'b0, 10'd300, 1'b0, 1'b0, 0, 0, dir, sl, sr, 0, -1);
        cyc({tag, ".f2"},  1'b1, 10'd300, 1'b0, 1'b0, 0, 0, dir, sl, sr, 0, -1);
        cyc({tag, ".g2"},  1'b0, 10'd300, 1'b0, 1'b0, 0, 0, dir, sl, sr, 0, -1);
        cyc({tag, ".f3"},  1'b1, 10'd300, 1'b0, 1'b0, 1, 1, dir, sl, sr, 0, -1);
        cyc({tag, ".run"}, 1'b0, 10'd300, 1'b0, 1'b0, 1, 0, dir, sl, sr, 0, -1);
    endtask

    initial begin
        m_if.new_frame_i = 1'b0;
        m_if.ball_x_i    = '0;
        m_if.start_i     = 1'b1;
        m_if.pause_i     = 1'b1;

        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("reset", 1'b0, 10'd0, 1'b1, 1'b1, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc("held_keys", 1'b1, 10'd0, 1'b1, 1'b1, 0, 0, 1, 0, 0, 0, 0);
        cyc("release", 1'b0, 10'd0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0);

        cyc("start", 1'b0, 10'd300, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0, -1);
        serve_seq("serve1", 1, 0, 0);

        cyc("goal_left_wall", 1'b1, 10'd0, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0, -1);
        serve_seq("serve2", 0, 0, 1);

        cyc("goal_and_pause", 1'b1, 10'd640, 1'b0, 1'b1, 0, 0, 1, 1, 1, 0, -1);
        cyc("pause_in_serve", 1'b0, 10'd300, 1'b0, 1'b0, 0, 0, 1, 1, 1, 0, -1);
        cyc("pause_in_serve2", 1'b0, 10'd300, 1'b0, 1'b1, 0, 0, 1, 1, 1, 0, -1);
        serve_seq("serve3", 1, 1, 1);

        cyc("pause_on", 1'b0, 10'd300, 1'b0, 1'b1, 0, 0, 1, 1, 1, 0, -1);
        cyc("paused_goal_l", 1'b1, 10'd0, 1'b0, 1'b0, 0, 0, 1, 1, 1, 0, -1);
        cyc("paused_goal_r", 1'b1, 10'd640, 1'b0, 1'b0, 0, 0, 1, 1, 1, 0, -1);
        cyc("pause_off", 1'b0, 10'd300, 1'b0, 1'b1, 1, 0, 1, 1, 1, 0, -1);
        cyc("resumed", 1'b0, 10'd300, 1'b0, 1'b0, 1, 0, 1, 1, 1, 0, -1);

        cyc("win_right", 1'b1, 10'd0, 1'b0, 1'b0, 0, 0, 0, 1, 2, 1, 1);
        cyc("over_hold", 1'b1, 10'd640, 1'b0, 1'b1, 0, 0, 0, 1, 2, 1, 1);
        cyc("over_hold2", 1'b0, 10'd0, 1'b0, 1'b0, 0, 0, 0, 1, 2, 1, 1);
        cyc("restart", 1'b0, 10'd300, 1'b1, 1'b1, 0, 0, 1, 0, 0, 0, -1);
        cyc("restart_idle", 1'b0, 10'd300, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, -1);
        serve_seq("serve4", 1, 0, 0);

        cyc("goal_pre_rst", 1'b1, 10'd0, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0, -1);
        cyc("serve_pre_rst", 1'b1, 10'd300, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0, -1);
        rst = 1'b1;
        cyc("mid_reset", 1'b0, 10'd300, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        cyc("post_reset", 1'b1, 10'd300, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0);
        cyc("idle_frames", 1'b1, 10'd300, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
